// File: rtl/spi_boot_master.sv
// Single-lane mode-0 SPI master: command, optional address, dummy cycles and a
// 32-bit data phase per request, with one response pulse per transaction.
module spi_boot_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic        cmd_has_addr,
  input  logic [31:0] cmd_addr,
  input  logic [5:0]  cmd_dummy,
  input  logic        cmd_is_read,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP} state_t;

  state_t        state_reg;
  logic [DW-1:0] div_reg;
  logic [7:0]    bit_reg;      // bits left in the current phase, minus one
  logic [31:0]   tx_reg;       // MSB is the bit currently on MOSI
  logic [31:0]   rx_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [5:0]    dummy_reg;
  logic          has_addr_reg;
  logic          is_read_reg;
  logic          tick;

  state_t        nxt_state;
  logic [7:0]    nxt_bits;
  logic [31:0]   nxt_tx;

  assign tick = (div_reg == DIV_LAST);

  // Phase that follows the current one once its last bit has been shifted out.
  always_comb begin
    nxt_state = DATA;
    nxt_bits  = 8'd31;
    nxt_tx    = is_read_reg ? 32'd0 : wdata_reg;
    case (state_reg)
      CMD: begin
        if (has_addr_reg) begin
          nxt_state = ADDR;
          nxt_tx    = addr_reg;
        end else if (dummy_reg != 6'd0) begin
          nxt_state = DUMMY;
          nxt_bits  = {2'b00, dummy_reg} - 8'd1;
          nxt_tx    = 32'd0;
        end
      end
      ADDR: begin
        if (dummy_reg != 6'd0) begin
          nxt_state = DUMMY;
          nxt_bits  = {2'b00, dummy_reg} - 8'd1;
          nxt_tx    = 32'd0;
        end
      end
      DATA: begin
        nxt_state = HOLD;
        nxt_tx    = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      spi_clk_o    <= 1'b0;
      spi_cs_o     <= 1'b1;
      spi_sdo_o    <= 1'b0;
      div_reg      <= '0;
      bit_reg      <= 8'd0;
      tx_reg       <= 32'd0;
      rx_reg       <= 32'd0;
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      dummy_reg    <= 6'd0;
      has_addr_reg <= 1'b0;
      is_read_reg  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      div_reg   <= tick ? '0 : div_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          div_reg <= '0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            spi_cs_o     <= 1'b0;
            spi_sdo_o    <= cmd_op[7];
            tx_reg       <= {cmd_op, 24'd0};
            bit_reg      <= 8'd7;
            rx_reg       <= 32'd0;
            addr_reg     <= cmd_addr;
            wdata_reg    <= cmd_wdata;
            dummy_reg    <= cmd_dummy;
            has_addr_reg <= cmd_has_addr;
            is_read_reg  <= cmd_is_read;
            state_reg    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) state_reg <= CMD;
        end
        CMD, ADDR, DUMMY, DATA: begin
          if (tick) begin
            if (!spi_clk_o) begin
              spi_clk_o <= 1'b1;
              if (state_reg == DATA && is_read_reg) rx_reg <= {rx_reg[30:0], spi_sdi_i};
            end else begin
              spi_clk_o <= 1'b0;
              if (bit_reg != 8'd0) begin
                bit_reg   <= bit_reg - 8'd1;
                tx_reg    <= {tx_reg[30:0], 1'b0};
                spi_sdo_o <= tx_reg[30];
              end else begin
                state_reg <= nxt_state;
                bit_reg   <= nxt_bits;
                tx_reg    <= nxt_tx;
                spi_sdo_o <= nxt_tx[31];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            spi_cs_o  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= is_read_reg ? rx_reg : 32'd0;
            state_reg <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            cmd_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_boot_master.sv
// Directed bench for spi_boot_master: two instances (CLK_DIV=4 and 1) share one
// SCLK-synchronous slave model selected by sel.
`timescale 1ns/1ps
module tb_spi_boot_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_op = 8'd0;
  logic        cmd_has_addr = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [5:0]  cmd_dummy = 6'd0;
  logic        cmd_is_read = 1'b0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        sdi = 1'b0;

  logic        ready4, ready1, rv4, rv1, sclk4, sclk1, cs4, cs1, sdo4, sdo1;
  logic [31:0] rdata4, rdata1;
  wire         spi_sclk  = sel ? sclk1 : sclk4;
  wire         spi_cs    = sel ? cs1 : cs4;
  wire         spi_sdo   = sel ? sdo1 : sdo4;
  wire         ready     = sel ? ready1 : ready4;
  wire         rsp_valid = sel ? rv1 : rv4;
  wire [31:0]  rsp_rdata = sel ? rdata1 : rdata4;
  wire         valid4    = cmd_valid & ~sel;
  wire         valid1    = cmd_valid & sel;
  int          cur_d;
  assign cur_d = sel ? 1 : 4;

  always #5 clk = ~clk;

  spi_boot_master #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .cmd_valid(valid4), .cmd_ready(ready4), .cmd_op(cmd_op),
    .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr), .cmd_dummy(cmd_dummy),
    .cmd_is_read(cmd_is_read), .cmd_wdata(cmd_wdata), .rsp_valid(rv4), .rsp_rdata(rdata4),
    .spi_clk_o(sclk4), .spi_cs_o(cs4), .spi_sdo_o(sdo4), .spi_sdi_i(sdi));

  spi_boot_master #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .cmd_valid(valid1), .cmd_ready(ready1), .cmd_op(cmd_op),
    .cmd_has_addr(cmd_has_addr), .cmd_addr(cmd_addr), .cmd_dummy(cmd_dummy),
    .cmd_is_read(cmd_is_read), .cmd_wdata(cmd_wdata), .rsp_valid(rv1), .rsp_rdata(rdata1),
    .spi_clk_o(sclk1), .spi_cs_o(cs1), .spi_sdo_o(sdo1), .spi_sdi_i(sdi));

  int cyc = 0;
  int rsp_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // Slave model: samples MOSI on SCLK rise, drives MISO after SCLK fall.
  logic [135:0] rx = '0;
  int           rises = 0;
  int           n_bits = 72;
  logic [31:0]  miso_word = 32'd0;
  int           period_err = 0;
  int           stable_err = 0;
  time          last_rise_t = 0;
  time          last_sdo_t = 0;
  logic         sclk_prev = 1'b0;
  logic         cs_prev = 1'b1;
  int           idx;

  always @(spi_sdo) last_sdo_t = $time;

  always @(spi_sclk or spi_cs) begin
    if (!spi_cs && cs_prev) begin
      rises = 0;
      rx    = '0;
    end
    if (!spi_cs && spi_sclk && !sclk_prev) begin
      if (rises > 0 && ($time - last_rise_t) != time'(2 * cur_d * 10)) period_err++;
      if (($time - last_sdo_t) < time'(cur_d * 10)) stable_err++;
      last_rise_t = $time;
      rises++;
      rx = {rx[134:0], spi_sdo};
    end
    if (!spi_cs && !spi_sclk && (sclk_prev || cs_prev)) begin
      idx = rises - (n_bits - 32);
      sdi = (idx >= 0 && idx < 32) ? miso_word[31 - idx] : 1'b0;
    end
    sclk_prev = spi_sclk;
    cs_prev   = spi_cs;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic [7:0] op, input logic ha, input logic [31:0] addr,
                           input logic [5:0] dm, input logic rd, input logic [31:0] wd,
                           input logic [31:0] mw, input logic keep, output int t0);
    n_bits       = 8 + (ha ? 32 : 0) + int'(dm) + 32;
    miso_word    = mw;
    cmd_op       = op;
    cmd_has_addr = ha;
    cmd_addr     = addr;
    cmd_dummy    = dm;
    cmd_is_read  = rd;
    cmd_wdata    = wd;
    cmd_valid    = 1'b1;
    t0 = -1;
    for (int i = 0; i < 100 && t0 < 0; i++) begin
      @(posedge clk); #1;
      if (!spi_cs) t0 = cyc;
    end
    if (!keep) cmd_valid = 1'b0;
    if (t0 < 0) check_eq("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] rdata, output int tr);
    tr = -1;
    rdata = 32'd0;
    for (int i = 0; i < 3000 && tr < 0; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        tr = cyc;
        rdata = rsp_rdata;
      end
    end
    if (tr < 0) check_eq("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_txn(input string tag, input logic [7:0] op, input logic ha,
                        input logic [31:0] addr, input logic [5:0] dm, input logic rd,
                        input logic [31:0] wd, input logic [31:0] mw, input int exp_lat,
                        input logic [31:0] exp_rdata);
    int t0, tr;
    logic [31:0] rdata;
    start_txn(op, ha, addr, dm, rd, wd, mw, 1'b0, t0);
    wait_rsp(rdata, tr);
    $display("txn %s: op=%02h lat=%0d rdata=%08h rises=%0d", tag, op, tr - t0, rdata, rises);
    check_eq({tag, "_lat"}, 64'(tr - t0), 64'(exp_lat));
    check_eq({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
    check_eq({tag, "_rises"}, 64'(rises), 64'(n_bits));
  endtask

  int t0, tr, a2, low_cnt, snap;
  logic [31:0] rd_word;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs", 64'(spi_cs), 64'd1);
    check_eq("rst_sclk", 64'(spi_sclk), 64'd0);
    check_eq("rst_sdo", 64'(spi_sdo), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready", 64'(ready), 64'd1);

    // Write, CLK_DIV=4: 72 bits, response at 4*(2*72+2)
    do_txn("wr4", 8'h02, 1'b1, 32'h0000_8000, 6'd0, 1'b0, 32'hDEADBEEF, 32'h0, 584, 32'h0);
    check_eq("wr4_op", 64'(rx[71:64]), 64'h02);
    check_eq("wr4_addr", 64'(rx[63:32]), 64'h0000_8000);
    check_eq("wr4_data", 64'(rx[31:0]), 64'hDEADBEEF);

    // Read with address and 32 dummy cycles: N=104
    do_txn("rd4", 8'h0B, 1'b1, 32'h1A10_0000, 6'd32, 1'b1, 32'hFFFF_FFFF, 32'hCAFEF00D, 840, 32'hCAFEF00D);
    check_eq("rd4_op", 64'(rx[103:96]), 64'h0B);
    check_eq("rd4_addr", 64'(rx[95:64]), 64'h1A10_0000);
    check_eq("rd4_mosi_zero", rx[63:0], 64'h0);

    // No address, no dummy: straight CMD->DATA, N=40
    do_txn("noaddr4", 8'h07, 1'b0, 32'hFFFF_FFFF, 6'd0, 1'b1, 32'h0, 32'h0000_0001, 328, 32'h1);
    check_eq("noaddr4_op", 64'(rx[39:32]), 64'h07);
    check_eq("noaddr4_period", 64'(period_err), 64'd0);
    check_eq("noaddr4_stable", 64'(stable_err), 64'd0);

    // cmd_valid toggled while busy must not start anything afterwards
    start_txn(8'h02, 1'b0, 32'h0, 6'd0, 1'b0, 32'h1234_5678, 32'h0, 1'b0, t0);
    for (int i = 0; i < 30; i++) begin
      cmd_valid = ~cmd_valid;
      @(posedge clk); #1;
    end
    check_eq("busy_ready", 64'(ready), 64'd0);
    cmd_valid = 1'b0;
    wait_rsp(rd_word, tr);
    low_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!spi_cs) low_cnt++;
    end
    $display("txn toggle: lat=%0d cs_low_after=%0d", tr - t0, low_cnt);
    check_eq("toggle_lat", 64'(tr - t0), 64'd328);
    check_eq("toggle_no_queue", 64'(low_cnt), 64'd0);

    // Back-to-back with cmd_valid held high
    start_txn(8'h02, 1'b1, 32'h0000_0100, 6'd0, 1'b0, 32'hA5A5_5A5A, 32'h0, 1'b1, t0);
    wait_rsp(rd_word, tr);
    a2 = -1;
    for (int i = 0; i < 20 && a2 < 0; i++) begin
      @(posedge clk); #1;
      if (!spi_cs) a2 = cyc;
    end
    cmd_valid = 1'b0;
    $display("txn b2b: first_lat=%0d accept_gap=%0d", tr - t0, a2 - tr);
    check_eq("b2b_first_lat", 64'(tr - t0), 64'd584);
    check_eq("b2b_accept_gap", 64'(a2 - tr), 64'd5);
    check_eq("b2b_cs_high_min", 64'(a2 - tr >= 4), 64'd1);
    wait_rsp(rd_word, tr);
    check_eq("b2b_second_lat", 64'(tr - a2), 64'd584);
    check_eq("b2b_second_data", 64'(rx[31:0]), 64'hA5A5_5A5A);

    // Reset at bit 20 of a read
    start_txn(8'h0B, 1'b1, 32'h1A10_0000, 6'd32, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, t0);
    for (int i = 0; i < 1000 && rises < 20; i++) begin
      @(posedge clk); #1;
    end
    check_eq("abort_reached_bit20", 64'(rises), 64'd20);
    snap = rsp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_cs", 64'(spi_cs), 64'd1);
    check_eq("abort_sclk", 64'(spi_sclk), 64'd0);
    check_eq("abort_sdo", 64'(spi_sdo), 64'd0);
    check_eq("abort_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    $display("txn abort: rsp_pulses_after=%0d ready=%0d", rsp_cnt - snap, ready);
    check_eq("abort_no_rsp", 64'(rsp_cnt - snap), 64'd0);
    check_eq("abort_ready", 64'(ready), 64'd1);
    do_txn("post_abort_wr", 8'h02, 1'b1, 32'h0000_8000, 6'd0, 1'b0, 32'h0BAD_F00D, 32'h0, 584, 32'h0);
    check_eq("post_abort_data", 64'(rx[31:0]), 64'h0BAD_F00D);

    // CLK_DIV=1 sweep
    sel = 1'b1;
    @(posedge clk); #1;
    do_txn("wr1", 8'h02, 1'b1, 32'h0000_8000, 6'd0, 1'b0, 32'hDEADBEEF, 32'h0, 146, 32'h0);
    check_eq("wr1_bits", rx[71:8], {8'h02, 32'h0000_8000, 24'hDEADBE});
    do_txn("rd1", 8'h0B, 1'b1, 32'h1A10_0000, 6'd32, 1'b1, 32'h0, 32'hCAFEF00D, 210, 32'hCAFEF00D);
    check_eq("rd1_mosi_zero", rx[63:0], 64'h0);
    check_eq("div1_period", 64'(period_err), 64'd0);
    check_eq("div1_stable", 64'(stable_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_boot_master.md
# spi_boot_master

Single-lane SPI master that issues one transaction per request to the chip's SPI slave port. It is the initiator end of the SPI link, driving `spi_clk_i`, `spi_cs_i` and `spi_sdi0_i`, and sampling `spi_sdo0_o`. It sits in the FPGA/tester harness as the boot loader and debug access path, and moves one 32-bit word per transaction. The phase sequence is command, optional address, dummy cycles, then data.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: request valid.
- `cmd_ready` out 1: block idle and able to accept a request.
- `cmd_op` in 8: SPI command byte.
- `cmd_has_addr` in 1: send the 32-bit address phase.
- `cmd_addr` in 32: address.
- `cmd_dummy` in 6: dummy SCLK cycles, 0..63.
- `cmd_is_read` in 1: 1 = read 32 data bits, 0 = write `cmd_wdata`.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle pulse at transaction end.
- `rsp_rdata` out 32: captured read word; 0 after a write.
- `spi_clk_o` out 1: SCLK to slave.
- `spi_cs_o` out 1: chip select, active low.
- `spi_sdo_o` out 1: MOSI to slave `sdi0`.
- `spi_sdi_i` in 1: MISO from slave `sdo0`; the slave is synchronous to SCLK.

## Operation
- SPI mode 0: SCLK idles low, MSB first on every phase. The master changes MOSI while SCLK is low; both sides sample on the SCLK rising edge.
- Request is accepted on a `clk` edge where `cmd_valid && cmd_ready`. All `cmd_*` fields are registered at acceptance. `cmd_ready` is 0 from the following cycle until the block returns to IDLE.
- States and transitions:
  - IDLE → SETUP on accept.
  - SETUP → CMD.
  - CMD (8 bits) → ADDR if `has_addr`, else DUMMY if `dummy≠0`, else DATA.
  - ADDR (32 bits) → DUMMY or DATA.
  - DUMMY (`dummy` bits) → DATA.
  - DATA (32 bits) → HOLD → GAP → IDLE.
- MOSI content per phase:
  - CMD: `cmd_op[7:0]`.
  - ADDR: `cmd_addr[31:0]`.
  - DUMMY: 0.
  - DATA write: `cmd_wdata[31:0]`.
  - DATA read: 0.
- Read capture: in DATA with `is_read`, `spi_sdi_i` is shifted into the capture register (MSB first) on the `clk` edge that drives `spi_clk_o` 0→1. MISO is ignored in every other phase.
- Bit count N = 8 + 32·has_addr + dummy + 32 (max 135). Use an 8-bit bit counter and a divider counter of width `$clog2(CLK_DIV)`, minimum 1.
- `rsp_rdata` updates only when `rsp_valid` pulses and holds between pulses.
- `cmd_valid` while busy is ignored; no queueing.

## Timing
- Reset values, forced on the first edge with `rst`=1 regardless of state:
  - `spi_cs_o`=1, `spi_clk_o`=0, `spi_sdo_o`=0.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `cmd_ready`=1 in the cycle after reset deasserts.
- Reset mid-transaction aborts it: CS rises and SCLK drops on the same edge, and no `rsp_valid` is produced.
- Accept at edge T0. `spi_cs_o` falls at T0, and MOSI carries `cmd_op[7]` from T0.
- SETUP: CLK_DIV cycles with SCLK low.
- Each bit is CLK_DIV cycles low followed by CLK_DIV cycles high.
- MOSI advances to the next bit on the edge that drives SCLK 1→0.
- HOLD: CLK_DIV cycles with SCLK low after the last falling edge. CS stays low through HOLD.
- CS rises and `rsp_valid` pulses on edge T0 + CLK_DIV·(2N+2).
- GAP: CS high for CLK_DIV cycles. `cmd_ready` reasserts on the following edge, giving a minimum CS-high time of CLK_DIV cycles.
- `dummy`=0 with `has_addr`=0 goes straight CMD→DATA with no extra SCLK cycles.
- CLK_DIV=1: SCLK = `clk`/2 and the timing above still holds exactly.

## Test plan
- Write, CLK_DIV=4: `op`=0x02, `addr`=0x0000_8000, `wdata`=0xDEADBEEF.
  - Slave model receives 72 bits 0x02, 0x00008000, 0xDEADBEEF.
  - `rsp_valid` pulses at T0+584; `rsp_rdata`=0.
- Read: `op`=0x0B, `addr`=0x1A10_0000, `dummy`=32, model returns 0xCAFEF00D.
  - N=104; `rsp_rdata`=0xCAFEF00D.
  - MOSI is 0 for the last 64 bits.
- No-address command: `op`=0x07, `has_addr`=0, `dummy`=0, read, model returns 0x0000_0001.
  - 40 SCLK rising edges; `rsp_rdata`=1.
- Back-to-back: hold `cmd_valid` high for two requests.
  - The second is accepted exactly CLK_DIV+1 cycles after the first `rsp_valid`.
  - CS stays high ≥CLK_DIV cycles between them.
  - `cmd_valid` toggled while busy is ignored.
- Reset at bit 20 of a read.
  - Next edge: CS=1, SCLK=0, MOSI=0, `rsp_valid` never asserts.
  - A following write completes correctly.
- CLK_DIV=1 sweep of the write and read cases.
  - Checker verifies SCLK period = 2 cycles, MOSI stable at every rising edge, and the same data results.
